// File: rtl/output_layer_classifier_if.sv
// Port bundle between the output-layer classifier, the hidden layer feeding it
// and the downstream consumer of the winning class.
interface output_layer_classifier_if #(
   parameter int unsigned N_HIDDEN = 10,
   parameter int unsigned N_OUT    = 10,
   parameter int unsigned DW       = 16
);
   logic                       start;
   logic [N_HIDDEN-1:0]        hidden_mac_valid;
   logic signed [DW-1:0]       hidden_relu_out [N_HIDDEN];
   logic [N_HIDDEN-1:0]        hidden_relu_valid;
   logic signed [DW-1:0]       weights_out [N_HIDDEN][N_OUT];
   logic signed [DW-1:0]       biases_out [N_OUT];
   logic                       busy;
   logic                       class_valid;
   logic                       class_ready;
   logic [3:0]                 class_out;
   logic signed [DW-1:0]       class_score;
   logic                       err_timeout;

   modport master (
      input  start, hidden_relu_out, hidden_relu_valid, weights_out, biases_out, class_ready,
      output hidden_mac_valid, busy, class_valid, class_out, class_score, err_timeout
   );

   modport slave (
      output start, hidden_relu_out, hidden_relu_valid, weights_out, biases_out, class_ready,
      input  hidden_mac_valid, busy, class_valid, class_out, class_score, err_timeout
   );
endinterface

// File: rtl/output_layer_classifier.sv
// Requests one hidden-layer evaluation, captures the activations, runs a serial
// fixed-point MAC over the output layer and presents the argmax class.
module output_layer_classifier #(
   parameter int unsigned N_HIDDEN = 10,
   parameter int unsigned N_OUT    = 10,
   parameter int unsigned DW       = 16,
   parameter int unsigned FRAC     = 8,
   parameter int unsigned ACC_W    = 40,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic                       clk,
   input  logic                       reset,
   output_layer_classifier_if.master  bus
);
   localparam int unsigned IW = (N_HIDDEN > 1) ? $clog2(N_HIDDEN) : 1;
   localparam int unsigned OW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam int unsigned PW = 2 * DW;
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DW - 1)) - 64'sd1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [2:0] {IDLE, REQ, WAIT, MAC, DONE} state_t;

   state_t                   state;
   logic [N_HIDDEN-1:0]      mask;
   logic signed [DW-1:0]     h_reg [N_HIDDEN];
   logic [TW-1:0]            wait_cnt;
   logic [IW-1:0]            i_cnt;
   logic [OW-1:0]            j_cnt;
   logic signed [ACC_W-1:0]  acc;
   logic signed [DW-1:0]     best_score;
   logic [OW-1:0]            best_idx;

   logic signed [PW-1:0]     prod;
   logic signed [ACC_W-1:0]  acc_base;
   logic signed [ACC_W-1:0]  acc_sum;
   logic signed [ACC_W-1:0]  acc_shr;
   logic signed [DW-1:0]     score;
   logic signed [DW-1:0]     win_score;
   logic [OW-1:0]            win_idx;
   logic                     take;
   logic [N_HIDDEN-1:0]      new_mask;

   // MAC datapath: bias seeds the accumulator on the first hidden index of each output
   always_comb begin
      prod     = PW'(h_reg[i_cnt]) * PW'(bus.weights_out[i_cnt][j_cnt]);
      acc_base = (i_cnt == '0) ? (ACC_W'(bus.biases_out[j_cnt]) <<< FRAC) : acc;
      acc_sum  = acc_base + ACC_W'(prod);
      acc_shr  = acc_sum >>> FRAC;
      if (acc_shr > SAT_MAX) begin
         score = SAT_MAX[DW-1:0];
      end else if (acc_shr < SAT_MIN) begin
         score = SAT_MIN[DW-1:0];
      end else begin
         score = acc_shr[DW-1:0];
      end
      // strict compare keeps the lowest index on ties
      take      = (j_cnt == '0) || (score > best_score);
      win_score = take ? score : best_score;
      win_idx   = take ? j_cnt : best_idx;
      new_mask  = mask | bus.hidden_relu_valid;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state                <= IDLE;
         mask                 <= '0;
         wait_cnt             <= '0;
         i_cnt                <= '0;
         j_cnt                <= '0;
         acc                  <= '0;
         best_score           <= '0;
         best_idx             <= '0;
         for (int k = 0; k < N_HIDDEN; k++) h_reg[k] <= '0;
         bus.hidden_mac_valid <= '0;
         bus.busy             <= 1'b0;
         bus.class_valid      <= 1'b0;
         bus.class_out        <= '0;
         bus.class_score      <= '0;
         bus.err_timeout      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state                <= REQ;
                  bus.busy             <= 1'b1;
                  bus.err_timeout      <= 1'b0;
                  bus.hidden_mac_valid <= '1;
               end
            end
            REQ: begin
               bus.hidden_mac_valid <= '0;
               mask                 <= '0;
               wait_cnt             <= '0;
               state                <= WAIT;
            end
            WAIT: begin
               for (int k = 0; k < N_HIDDEN; k++) begin
                  if (bus.hidden_relu_valid[k]) h_reg[k] <= bus.hidden_relu_out[k];
               end
               mask <= new_mask;
               if (&new_mask) begin
                  i_cnt <= '0;
                  j_cnt <= '0;
                  state <= MAC;
               end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                  bus.err_timeout <= 1'b1;
                  bus.busy        <= 1'b0;
                  state           <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + TW'(1);
               end
            end
            MAC: begin
               acc <= acc_sum;
               if (i_cnt == IW'(N_HIDDEN - 1)) begin
                  i_cnt      <= '0;
                  best_score <= win_score;
                  best_idx   <= win_idx;
                  if (j_cnt == OW'(N_OUT - 1)) begin
                     bus.class_out   <= 4'(win_idx);
                     bus.class_score <= win_score;
                     bus.class_valid <= 1'b1;
                     state           <= DONE;
                  end else begin
                     j_cnt <= j_cnt + OW'(1);
                  end
               end else begin
                  i_cnt <= i_cnt + IW'(1);
               end
            end
            DONE: begin
               if (bus.class_ready) begin
                  bus.class_valid <= 1'b0;
                  bus.busy        <= 1'b0;
                  state           <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_output_layer_classifier.sv
// Scoreboard bench for output_layer_classifier: stimulus pushes expected
// results, a separate monitor pops them on each class handshake.
module tb_output_layer_classifier;
   localparam int NH = 10;
   localparam int NO = 10;

   typedef struct {
      int     idx;
      longint score;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   exp_t exp_q[$];

   logic signed [15:0] th [NH];
   logic signed [15:0] tw [NH][NO];
   logic signed [15:0] tbias [NO];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   output_layer_classifier_if #(.N_HIDDEN(NH), .N_OUT(NO), .DW(16)) bus ();

   output_layer_classifier #(
      .N_HIDDEN(NH), .N_OUT(NO), .DW(16), .FRAC(8), .ACC_W(40), .TIMEOUT(255)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string nm, input longint act, input longint exp_v);
      total++;
      if (act != exp_v) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
      end
   endtask

   // Reference: real-valued layer scaled by 256, floor to Q8.8, clamp, first maximum wins
   function automatic exp_t model();
      exp_t   r;
      longint acc, s, best;
      r.idx = 0;
      best  = 0;
      for (int j = 0; j < NO; j++) begin
         acc = longint'(tbias[j]) * 256;
         for (int i = 0; i < NH; i++) acc += longint'(th[i]) * longint'(tw[i][j]);
         s = acc >>> 8;
         if (s > 32767) s = 32767;
         else if (s < -32768) s = -32768;
         if (j == 0 || s > best) begin
            best  = s;
            r.idx = j;
         end
      end
      r.score = best;
      return r;
   endfunction

   task automatic load_params();
      for (int i = 0; i < NH; i++)
         for (int j = 0; j < NO; j++) bus.weights_out[i][j] = tw[i][j];
      for (int j = 0; j < NO; j++) bus.biases_out[j] = tbias[j];
   endtask

   // Drive one cycle of valids; unselected bits and garbage cycles carry random data
   task automatic drive_valid(input logic [NH-1:0] m, input bit garbage);
      bus.hidden_relu_valid = m;
      for (int i = 0; i < NH; i++)
         bus.hidden_relu_out[i] = (garbage || !m[i]) ? 16'($urandom) : th[i];
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input logic signed [15:0] hv, input int wcol, input logic signed [15:0] wv);
      for (int i = 0; i < NH; i++) begin
         th[i] = hv;
         for (int j = 0; j < NO; j++) tw[i][j] = (j == wcol) ? wv : 16'sd0;
      end
      for (int j = 0; j < NO; j++) tbias[j] = 16'sd0;
   endtask

   task automatic rand_data(input bit wide);
      for (int i = 0; i < NH; i++) begin
         th[i] = wide ? 16'($urandom) : 16'($urandom_range(0, 1024));
         for (int j = 0; j < NO; j++)
            tw[i][j] = wide ? 16'($urandom) : 16'($urandom_range(0, 1024)) - 16'd512;
      end
      for (int j = 0; j < NO; j++)
         tbias[j] = wide ? 16'($urandom) : 16'($urandom_range(0, 2048)) - 16'd1024;
   endtask

   task automatic check_all_zero(input string pfx);
      check({pfx, "_busy"}, bus.busy, 0);
      check({pfx, "_valid"}, bus.class_valid, 0);
      check({pfx, "_class"}, bus.class_out, 0);
      check({pfx, "_score"}, bus.class_score, 0);
      check({pfx, "_err"}, bus.err_timeout, 0);
      check({pfx, "_req"}, bus.hidden_mac_valid, 0);
   endtask

   // mode: 0 all at once, 1 reverse one per cycle, 2 random spread, 3 withhold bit 4, 4 reset mid-MAC
   task automatic run_txn(input int mode, input int hold, input bit directed,
                          input int d_idx, input longint d_score);
      exp_t            e;
      int              r, t0;
      bit              seen;
      logic [NH-1:0]   pend, m;
      load_params();
      bus.hidden_relu_valid = '0;
      bus.class_ready = (hold == 0);
      @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      @(negedge clk);
      check("req_pulse", bus.hidden_mac_valid, 1023);
      check("req_busy", bus.busy, 1);
      check("req_err_clear", bus.err_timeout, 0);
      r = cyc;
      @(negedge clk);
      check("req_one_cycle", bus.hidden_mac_valid, 0);
      @(posedge clk); #1;
      t0 = cyc;
      case (mode)
         0, 4: begin
            t0 = cyc;
            drive_valid('1, 1'b0);
         end
         1: begin
            for (int k = NH - 1; k >= 0; k--) begin
               t0 = cyc;
               drive_valid(NH'(1) << k, 1'b0);
            end
         end
         2: begin
            for (int k = 0; k < 3; k++) drive_valid(NH'($urandom) & ~NH'(1), 1'b1);
            pend = ~NH'(1);
            while (pend != '0) begin
               m = pend & NH'($urandom);
               pend &= ~m;
               drive_valid(m, 1'b0);
            end
            t0 = cyc;
            drive_valid(NH'(1), 1'b0);
            for (int k = 0; k < 3; k++) drive_valid(NH'($urandom), 1'b1);
         end
         default: drive_valid(~(NH'(1) << 4), 1'b0);
      endcase
      bus.hidden_relu_valid = '0;

      if (mode == 3) begin
         seen = 1'b0;
         for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk);
            seen = bus.err_timeout;
         end
         check("timeout_seen", seen, 1);
         check("timeout_cycles", cyc - r, 256);
         check("timeout_idle", bus.busy, 0);
         check("timeout_no_valid", bus.class_valid, 0);
         return;
      end
      if (mode == 4) begin
         repeat (30) @(posedge clk);
         #1 reset = 1'b0;
         #1 check_all_zero("abort");
         repeat (2) @(posedge clk);
         #1 reset = 1'b1;
         return;
      end

      if (directed) begin
         e.idx   = d_idx;
         e.score = d_score;
      end else begin
         e = model();
      end
      exp_q.push_back(e);

      seen = 1'b0;
      for (int k = 0; k < 200 && !seen; k++) begin
         @(negedge clk);
         seen = bus.class_valid;
      end
      check("result_seen", seen, 1);
      check("latency", cyc - t0, 101);
      if (hold > 0) begin
         bus.start = 1'b1;
         for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_valid", bus.class_valid, 1);
            check("hold_class", bus.class_out, e.idx);
            check("hold_score", bus.class_score, e.score);
            check("hold_no_req", bus.hidden_mac_valid, 0);
         end
         @(posedge clk); #1;
         bus.start = 1'b0;
         bus.class_ready = 1'b1;
         @(posedge clk); #1 bus.class_ready = 1'b0;
      end
      @(negedge clk);
      check("ack_valid_drop", bus.class_valid, 0);
      check("ack_idle", bus.busy, 0);
      check("ack_keep_class", bus.class_out, e.idx);
      check("ack_keep_score", bus.class_score, e.score);
   endtask

   // Monitor: every accepted result must match the oldest expectation
   initial begin
      forever begin
         exp_t e;
         @(negedge clk);
         if (reset && bus.class_valid && bus.class_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_unexpected: got class %0d with nothing expected", bus.class_out);
            end else begin
               e = exp_q.pop_front();
               check("sb_class", bus.class_out, e.idx);
               check("sb_score", bus.class_score, e.score);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int modes [8] = '{2, 0, 2, 1, 2, 2, 0, 2};
      bus.start = 1'b0;
      bus.class_ready = 1'b0;
      bus.hidden_relu_valid = '0;
      for (int i = 0; i < NH; i++) bus.hidden_relu_out[i] = '0;
      set_data(16'sh0100, 3, 16'sh0100);
      load_params();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1 reset = 1'b1;

      set_data(16'sh0100, 3, 16'sh0100);
      run_txn(0, 0, 1'b1, 3, 32'sh0A00);
      run_txn(1, 0, 1'b1, 3, 32'sh0A00);

      set_data(16'sh0100, 0, 16'sh0000);
      tbias[5] = 16'sh0200;
      tbias[7] = 16'sh0200;
      run_txn(0, 0, 1'b1, 5, 32'sh0200);

      set_data(16'sh7FFF, 2, 16'sh7FFF);
      run_txn(0, 0, 1'b1, 2, 32'sh7FFF);

      run_txn(3, 0, 1'b0, 0, 0);

      set_data(16'sh0100, 3, 16'sh0100);
      run_txn(0, 20, 1'b1, 3, 32'sh0A00);

      set_data(16'sh0100, 6, 16'sh0080);
      run_txn(4, 0, 1'b0, 0, 0);
      set_data(16'sh0100, 3, 16'sh0100);
      run_txn(0, 0, 1'b1, 3, 32'sh0A00);

      for (int n = 0; n < 8; n++) begin
         rand_data(n[0]);
         if (n == 3) begin
            for (int i = 0; i < NH; i++) tw[i][7] = tw[i][2];
            tbias[7] = tbias[2];
         end
         run_txn(modes[n], int'($urandom_range(0, 3)), 1'b0, 0, 0);
      end

      repeat (5) @(negedge clk);
      check("sb_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
